cordic_arbiter: RTL and testbench
=================================

# cordic_arbiter

Round-robin arbiter and tag scheduler that shares one fully pipelined CORDIC cosine datapath among `NREQ` requesters. It accepts at most one float32 angle per cycle, drives it into the datapath, and tracks the requester ID of every in-flight operation in a tag pipeline matched to the datapath latency. When a result emerges, the block returns it to the owning requester. It sits between the compute clients and the CORDIC core and owns all flow control, since the core has no valid or stall signals.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `LATENCY`, 21: edges from `cordic_theta` update to the matching `cordic_result` update.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input NREQ: requester i has an angle pending.
- `req_theta` input NREQ*32: float32 angle for requester i, in bits [32i+31:32i].
- `req_ready` output NREQ: one-hot grant; a transfer occurs for i when `req_valid[i] && req_ready[i]`.
- `cordic_theta` output 32: registered angle to the datapath.
- `cordic_result` input 32: float32 result from the datapath.
- `resp_valid` output NREQ: one-hot, one-cycle pulse marking a result for requester i.
- `resp_result` output 32: float32 result, valid while any `resp_valid` bit is set.
- `inflight` output 6: count of accepted operations not yet responded.

## Operation
- **Grant**
  - Combinational round robin starting at `(last + 1) mod NREQ`.
  - `req_ready[i]` is 1 only for the first requester with `req_valid` set; all bits are 0 if no request is valid.
  - `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Pointer**: on a transfer, `last` <= granted ID. When there is no transfer, `last` holds.
- **Issue**
  - On a transfer, `cordic_theta` <= the granted `req_theta` slice.
  - Otherwise `cordic_theta` holds its value, and that value is ignored downstream.
- **Tag pipeline**
  - Shift register of `LATENCY+1` entries `{valid, id[2:0]}`.
  - Stage 0 <= `{transfer, granted id}` every edge. Stage k <= stage k-1.
- **Response**
  - Tail stage valid in a cycle means `cordic_result` holds that operation's result.
  - At the next edge, `resp_valid` <= one-hot(tail id) and `resp_result` <= `cordic_result`.
  - Otherwise `resp_valid` <= 0 and `resp_result` holds.
- **In-flight count**
  - `inflight` is incremented on a transfer and decremented on an edge that sets a `resp_valid` bit.
  - Both events on the same edge leave it unchanged. Maximum value is `LATENCY+1`.
- **No backpressure**
  - The datapath cannot stall, so every accepted request produces exactly one response.
  - Requesters must sink `resp_valid` every cycle.
- **Ordering**
  - Responses return in acceptance order, globally and per requester.
- **Reset**
  - Clears the `last` pointer (to NREQ-1, so requester 0 wins first), `cordic_theta`, `resp_result` and `inflight` to 0, `resp_valid` to 0, and every tag valid bit.
  - Datapath contents are not reset. Operations in flight at reset are silently dropped and never produce `resp_valid`.
- **Width**: angle and result data pass through unmodified; the block performs no arithmetic on them.

## Timing
- Accept at edge E, meaning `req_valid[i] && req_ready[i]` is high in the cycle ending at E.
- `cordic_theta` is updated at E, and `cordic_result` is updated at E+`LATENCY`.
- `resp_valid[i]` and `resp_result` are updated at E+`LATENCY`+1.
- End-to-end latency is `LATENCY`+1 = 22 edges.
- Throughput is 1 accept per cycle in aggregate.
- With all requesters active, each receives a grant exactly once per `NREQ` cycles.
- Reset output values: `req_ready` is combinational and equals the round-robin grant from requester 0 up. `cordic_theta`=0, `resp_valid`=0, `resp_result`=0, `inflight`=0.
- Reset asserted mid-operation: all tag valids clear immediately (asynchronous). After deassertion, no `resp_valid` appears for 22 edges unless a new accept occurs.

## Test plan
- **Single request**: `req_valid[2]` high one cycle, theta=0x00000000.
  - Expect `req_ready`=4'b0100 and `resp_valid`=4'b0100 exactly 22 edges later.
  - Expect `resp_result` ≈ 0x3F800000 (1.0, within 4 ulp); `inflight` goes 1 then 0.
- **Simultaneous requests**: `req_valid`=4'b1010 held, after reset.
  - Expect grants alternating 1,3,1,3.
  - Expect responses alternating 1,3 at 22-edge offset, each carrying its own theta's cosine.
- **Full load**: all four valid for 40 cycles with distinct thetas.
  - Expect grants 0,1,2,3 repeating.
  - Expect `inflight` saturating at 22 and responses in accept order with no gaps.
- **Single-requester streaming**: requester 0 sends 30 back-to-back thetas (0.0, 0.1, ...).
  - Expect 30 consecutive `resp_valid[0]` pulses, in order, with no drops.
- **Reset mid-flight**: issue 5 requests, then assert `reset` 10 cycles later for 1 cycle.
  - Expect zero `resp_valid` for the next 30 cycles and `inflight`=0.
  - A new request afterwards responds normally at +22.
- **Simultaneous accept and response**: steady single stream.
  - Expect `inflight` constant at 22 while accept and response coincide.

Source files
------------

// File: rtl/cordic_arbiter_if.sv
// Requester-side handshake bundle for cordic_arbiter: angle requests in,
// one-hot grants and one-hot result pulses out.
interface cordic_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_theta;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [DATA_W-1:0]      resp_result;

    modport master (
        output req_valid, req_theta,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_theta,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin front end for a stall-free CORDIC pipeline: grants one angle per
// cycle and steers each result back to its requester via a matched tag pipeline.
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 21,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    cordic_arbiter_if.slave   bus,
    output logic [DATA_W-1:0] cordic_theta,
    input  logic [DATA_W-1:0] cordic_result,
    output logic [5:0]        inflight
);

    logic [2:0]        r_last;
    logic [DATA_W-1:0] r_theta_p0;
    logic [LATENCY:0]  r_tag_vld;
    logic [2:0]        r_tag_id [0:LATENCY];
    logic [NREQ-1:0]   r_resp_valid;
    logic [DATA_W-1:0] r_resp_result;
    logic [5:0]        r_inflight;

    logic [NREQ-1:0]   w_ready;
    logic [2:0]        w_gnt_id;
    logic              w_xfer;
    logic [DATA_W-1:0] w_gnt_theta;
    logic              w_tail_vld;
    logic [NREQ-1:0]   w_tail_onehot;

    // Grant: search requesters starting one past the last winner.
    always_comb begin
        int idx;
        w_gnt_id = '0;
        w_xfer   = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_last) + 1 + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!w_xfer && (i == idx) && bus.req_valid[i]) begin
                    w_xfer   = 1'b1;
                    w_gnt_id = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_ready     = '0;
        w_gnt_theta = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = w_xfer && (w_gnt_id == 3'(i));
            if (w_gnt_id == 3'(i)) begin
                w_gnt_theta = bus.req_theta[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_tail_vld = r_tag_vld[LATENCY];

    always_comb begin
        w_tail_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_tail_onehot[i] = (r_tag_id[LATENCY] == 3'(i));
        end
    end

    // Issue stage, tag valid chain, response stage and occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last        <= 3'(NREQ - 1);
            r_theta_p0    <= '0;
            r_tag_vld     <= '0;
            r_resp_valid  <= '0;
            r_resp_result <= '0;
            r_inflight    <= '0;
        end else begin
            if (w_xfer) begin
                r_last     <= w_gnt_id;
                r_theta_p0 <= w_gnt_theta;
            end
            r_tag_vld    <= {r_tag_vld[LATENCY-1:0], w_xfer};
            r_resp_valid <= w_tail_vld ? w_tail_onehot : '0;
            if (w_tail_vld) begin
                r_resp_result <= cordic_result;
            end
            case ({w_xfer, w_tail_vld})
                2'b10:   r_inflight <= r_inflight + 6'd1;
                2'b01:   r_inflight <= r_inflight - 6'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Tag ids only matter while their valid bit is set, so they need no reset.
    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_gnt_id;
        for (int k = 1; k <= LATENCY; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_result = r_resp_result;
    assign cordic_theta    = r_theta_p0;
    assign inflight        = r_inflight;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural stand-in for the
// CORDIC datapath (fixed-latency bijective transform).
module tb_cordic_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 21;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic reset;
    logic [DW-1:0] cordic_theta;
    logic [DW-1:0] cordic_result;
    logic [5:0]    inflight;

    always #5 clk = ~clk;

    cordic_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) bus ();

    cordic_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .cordic_theta  (cordic_theta),
        .cordic_result (cordic_result),
        .inflight      (inflight)
    );

    function automatic logic [31:0] dp_fn(input logic [31:0] x);
        return {x[15:0], ~x[31:16]};
    endfunction

    // Datapath stand-in: not reset, LAT edges from cordic_theta to cordic_result.
    logic [31:0] dp [0:LAT-1];
    always @(posedge clk) begin
        dp[0] <= dp_fn(cordic_theta);
        for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
    end
    assign cordic_result = dp[LAT-1];

    typedef struct {
        logic [3:0]  id_oh;
        logic [31:0] res;
        int          acc;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_id;
    logic [31:0] pend_theta;
    bit          chk_theta = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] rr_pick(input logic [3:0] v, input int last);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (last + 1 + k) % NREQ;
            if (v[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    task automatic step(input logic [3:0] v, input logic [127:0] th);
        logic [3:0] g;
        exp_t e;
        @(posedge clk);
        #1;
        if (chk_theta) begin
            checks++;
            if (cordic_theta !== pend_theta) begin
                failures++;
                $display("FAIL cordic_theta got=%h want=%h", cordic_theta, pend_theta);
            end
        end
        chk_theta = 0;
        bus.req_valid = v;
        bus.req_theta = th;
        #1;
        g = rr_pick(v, last_id);
        checks++;
        if (bus.req_ready !== g) begin
            failures++;
            $display("FAIL req_ready got=%b want=%b valid=%b", bus.req_ready, g, v);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                e.id_oh = g;
                e.res   = dp_fn(th[i*32 +: 32]);
                e.acc   = cyc + 1;
                e.due   = cyc + 1 + LAT + 1;
                q.push_back(e);
                last_id    = i;
                pend_theta = th[i*32 +: 32];
                chk_theta  = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        reset         = 1'b1;
        q.delete();
        last_id   = NREQ - 1;
        chk_theta = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every cycle compare any response and the occupancy count.
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge clk);
            if (bus.resp_valid != '0) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected got=%b want=0000 cyc=%0d", bus.resp_valid, cyc);
                end else begin
                    e = q.pop_front();
                    if (bus.resp_valid !== e.id_oh || bus.resp_result !== e.res || cyc != e.due) begin
                        failures++;
                        $display("FAIL resp got id=%b res=%h cyc=%0d want id=%b res=%h cyc=%0d",
                                 bus.resp_valid, bus.resp_result, cyc, e.id_oh, e.res, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL resp_missing got=0000 want=%b due=%0d", q[0].id_oh, q[0].due);
                void'(q.pop_front());
            end
            n = 0;
            foreach (q[j]) if (q[j].acc <= cyc) n++;
            checks++;
            if (int'(inflight) != n) begin
                failures++;
                $display("FAIL inflight got=%0d want=%0d cyc=%0d", inflight, n, cyc);
            end
        end
    end

    initial begin
        logic [127:0] th;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_theta = '0;
        last_id       = NREQ - 1;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (cordic_theta !== 32'h0)     begin failures++; $display("FAIL rst_theta got=%h want=0", cordic_theta); end
        if (bus.resp_valid !== 4'h0)    begin failures++; $display("FAIL rst_resp_valid got=%b want=0", bus.resp_valid); end
        if (bus.resp_result !== 32'h0)  begin failures++; $display("FAIL rst_resp_result got=%h want=0", bus.resp_result); end
        if (inflight !== 6'd0)          begin failures++; $display("FAIL rst_inflight got=%0d want=0", inflight); end
        bus.req_valid = 4'hF;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_ready got=%b want=0001", bus.req_ready); end
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request from requester 2 with theta 0.
        step(4'b0100, 128'h0);
        idle(LAT + 4);

        // Requesters 1 and 3 held together.
        for (int i = 0; i < 8; i++) step(4'b1010, {$urandom, $urandom, $urandom, $urandom});
        idle(LAT + 4);

        // Full load: all four requesters for 40 cycles.
        for (int i = 0; i < 40; i++) step(4'b1111, {$urandom, $urandom, $urandom, $urandom});
        idle(LAT + 4);

        // Requester 0 streams 30 back-to-back angles.
        for (int i = 0; i < 30; i++) begin
            th = {$urandom, $urandom, $urandom, 32'h3DCC_CCCD + 32'(i)};
            step(4'b0001, th);
        end
        idle(LAT + 4);

        // Reset while five operations are in flight.
        for (int i = 0; i < 5; i++) step(4'(1 << (i % NREQ)), {$urandom, $urandom, $urandom, $urandom});
        idle(10);
        pulse_reset();
        idle(30);
        checks++;
        if (inflight !== 6'd0) begin failures++; $display("FAIL post_reset_inflight got=%0d want=0", inflight); end
        step(4'b0010, {$urandom, $urandom, $urandom, $urandom});
        idle(LAT + 4);

        // Random traffic.
        for (int i = 0; i < 300; i++) step(4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});

        for (int i = 0; i < 60 && q.size() > 0; i++) idle(1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
